// File: rtl/conv3x3_scheduler.sv
// Raster-order sequencer for a 3x3 convolution: nine padded tap reads per pixel,
// MAC strobes one cycle behind the reads, then a ready/valid write of the result.
module conv3x3_scheduler #(
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              tap_valid,
    output logic              tap_pad,
    output logic [3:0]        tap_idx,
    output logic              tap_first,
    output logic              tap_last,
    input  logic              res_valid,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    input  logic              out_ready,
    output logic [2:0]        dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Coordinates are widened by two bits so x-1 / y-1 at the border go negative.
    localparam int CW = ADDR_W + 2;
    localparam logic [ADDR_W-1:0]    X_LAST = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0]    Y_LAST = ADDR_W'(IMG_H - 1);
    localparam logic signed [CW-1:0] X_MAX  = CW'(IMG_W - 1);
    localparam logic signed [CW-1:0] Y_MAX  = CW'(IMG_H - 1);
    localparam logic [CW-1:0]        W_C    = CW'(IMG_W);
    localparam logic [ADDR_W-1:0]    W_A    = ADDR_W'(IMG_W);

    state_t            state, state_n;
    logic [ADDR_W-1:0] x, y, x_n, y_n;
    logic [3:0]        k, k_n;
    logic              xfer, last_pix;
    logic [1:0]        tap_row, tap_col;
    logic [CW-1:0]     tx, ty, lin;
    logic              pad_n;
    logic [ADDR_W-1:0] tap_addr, pix_addr;

    assign xfer      = wr_en & out_ready;
    assign last_pix  = (x == X_LAST) && (y == Y_LAST);
    assign pix_addr  = y * W_A + x;
    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            x     <= '0;
            y     <= '0;
            k     <= '0;
        end else begin
            state <= state_n;
            x     <= x_n;
            y     <= y_n;
            k     <= k_n;
        end
    end

    always_comb begin
        state_n = state;
        x_n     = x;
        y_n     = y;
        k_n     = k;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_FETCH;
                    x_n     = '0;
                    y_n     = '0;
                    k_n     = '0;
                end
            end
            S_FETCH: begin
                if (k == 4'd8) state_n = S_WAIT;
                else           k_n     = k + 4'd1;
            end
            S_WAIT: begin
                if (res_valid) state_n = S_WRITE;
            end
            S_WRITE: begin
                if (xfer) begin
                    if (last_pix) begin
                        state_n = S_DONE;
                    end else begin
                        state_n = S_FETCH;
                        k_n     = '0;
                        if (x == X_LAST) begin
                            x_n = '0;
                            y_n = y + ADDR_W'(1);
                        end else begin
                            x_n = x + ADDR_W'(1);
                        end
                    end
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Tap geometry is evaluated for the next cycle's (x, y, k) so reads register in step with FETCH.
    always_comb begin
        tap_row  = 2'(k_n / 4'd3);
        tap_col  = 2'(k_n % 4'd3);
        tx       = {2'b00, x_n} + CW'(tap_col) - CW'(1);
        ty       = {2'b00, y_n} + CW'(tap_row) - CW'(1);
        pad_n    = tx[CW-1] || ty[CW-1] || (signed'(tx) > X_MAX) || (signed'(ty) > Y_MAX);
        lin      = ty * W_C + tx;
        tap_addr = lin[ADDR_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            tap_valid <= 1'b0;
            tap_pad   <= 1'b0;
            tap_idx   <= '0;
            tap_first <= 1'b0;
            tap_last  <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
        end else begin
            busy      <= (state_n != S_IDLE);
            done      <= (state_n == S_DONE);
            rd_en     <= (state_n == S_FETCH) && !pad_n;
            rd_addr   <= ((state_n == S_FETCH) && !pad_n) ? tap_addr : '0;
            // MAC strobes trail the read by one cycle to line up with BRAM data.
            tap_valid <= (state == S_FETCH);
            tap_pad   <= (state == S_FETCH) && !rd_en;
            tap_idx   <= (state == S_FETCH) ? k : 4'd0;
            tap_first <= (state == S_FETCH) && (k == 4'd0);
            tap_last  <= (state == S_FETCH) && (k == 4'd8);
            if (state == S_WAIT && res_valid) begin
                wr_en   <= 1'b1;
                wr_addr <= pix_addr;
            end else if (xfer) begin
                wr_en <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_conv3x3_scheduler.sv
// Bench for conv3x3_scheduler on a 4x3 image: a frame-level reference model
// predicts taps, writes, busy and done; directed frames pin the border cases.
module tb_conv3x3_scheduler;
    localparam int W    = 4;
    localparam int H    = 3;
    localparam int AW   = 4;
    localparam int NPIX = W * H;

    typedef struct {
        bit pad;
        int idx;
        int addr;
    } tap_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          res_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          busy, done, rd_en, tap_valid, tap_pad, tap_first, tap_last, wr_en;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [3:0]    tap_idx;
    logic [2:0]    dbg_state;

    conv3x3_scheduler #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .tap_valid(tap_valid), .tap_pad(tap_pad),
        .tap_idx(tap_idx), .tap_first(tap_first), .tap_last(tap_last),
        .res_valid(res_valid), .wr_en(wr_en), .wr_addr(wr_addr),
        .out_ready(out_ready), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int            n_cmp = 0;
    int            n_bad = 0;
    tap_t          exp_tap_q[$];
    logic [AW-1:0] exp_q[$];
    bit            busy_m, done_m, wr_m, armed;
    logic [AW-1:0] wr_addr_m;
    int            pix_m, first_cd, cyc, done_cnt, n_xfer;
    bit            prev_rd_en, prev_tap_valid;
    logic [AW-1:0] prev_rd_addr;
    int            obs_addr[NPIX][9];
    int            obs_n[NPIX];
    int            xfer_cyc[NPIX];
    int            mode = 0;
    bit            noise_en = 1'b0;
    bit            start_req = 1'b0;
    int            hold_cnt = 0;
    int            wcnt = -1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic build_frame();
        int px, py, xx, yy;
        tap_t t;
        exp_tap_q.delete();
        exp_q.delete();
        for (int p = 0; p < NPIX; p++) begin
            px = p % W;
            py = p / W;
            for (int k = 0; k < 9; k++) begin
                xx     = px + k % 3 - 1;
                yy     = py + k / 3 - 1;
                t.idx  = k;
                t.pad  = (xx < 0) || (xx >= W) || (yy < 0) || (yy >= H);
                t.addr = t.pad ? 0 : yy * W + xx;
                exp_tap_q.push_back(t);
            end
            exp_q.push_back(AW'(p));
            obs_n[p] = 0;
        end
    endtask

    task automatic model_reset();
        exp_tap_q.delete();
        exp_q.delete();
        busy_m = 0; done_m = 0; wr_m = 0; armed = 0; wr_addr_m = '0;
        pix_m = 0; first_cd = -1;
        prev_rd_en = 0; prev_tap_valid = 0; prev_rd_addr = '0;
    endtask

    function automatic int pad_mask(input int p);
        int m = 0;
        for (int k = 0; k < 9; k++)
            if (exp_tap_q[p * 9 + k].pad) m |= (1 << k);
        return m;
    endfunction

    // ---------------- stimulus driver ----------------
    always @(posedge clk) begin
        #1;
        start = start_req || (noise_en && busy && !done && $urandom_range(0, 7) == 0);
        if (tap_valid && tap_last) wcnt = 0;
        else if (wcnt >= 0)        wcnt++;
        case (mode)
            1: begin
                res_valid = ($urandom_range(0, 2) == 0);
                out_ready = ($urandom_range(0, 1) == 1);
            end
            2: begin
                if (wr_en && pix_m == 2 && hold_cnt < 5) begin
                    out_ready = 1'b0;
                    hold_cnt++;
                end else begin
                    out_ready = 1'b1;
                end
                if (pix_m == 3) res_valid = (wcnt == 7) || (tap_valid && tap_idx == 4'd3);
                else            res_valid = 1'b1;
            end
            default: begin
                res_valid = 1'b1;
                out_ready = 1'b1;
            end
        endcase
    end

    // ---------------- compare process + model ----------------
    tap_t t;
    bit   popped_last, xfer, accept, busy_n, done_n, wr_n;

    always @(negedge clk) begin
        if (!rst) begin
            popped_last = 0;
            check("busy", busy, busy_m);
            check("done", done, done_m);
            check("wr_en", wr_en, wr_m);
            if (wr_m) check("wr_addr", wr_addr, wr_addr_m);
            if (busy_m) check("tap_first_timing", tap_valid && tap_first, first_cd == 0);
            if (wr_en) check("rd_en_in_write", rd_en, 0);
            if (!rd_en) check("rd_addr_idle", rd_addr, 0);
            if (tap_valid) begin
                if (exp_tap_q.size() == 0) begin
                    check("tap_unexpected", 1, 0);
                end else begin
                    t = exp_tap_q.pop_front();
                    check("tap_idx", tap_idx, t.idx);
                    check("tap_pad", tap_pad, t.pad);
                    check("tap_first", tap_first, t.idx == 0);
                    check("tap_last", tap_last, t.idx == 8);
                    check("tap_rd_en", prev_rd_en, !t.pad);
                    if (!t.pad) begin
                        check("tap_rd_addr", prev_rd_addr, t.addr);
                        if (pix_m < NPIX && obs_n[pix_m] < 9) begin
                            obs_addr[pix_m][obs_n[pix_m]] = prev_rd_addr;
                            obs_n[pix_m]++;
                        end
                    end
                    if (t.idx != 0) check("tap_contig", prev_tap_valid, 1);
                    popped_last = (t.idx == 8);
                end
            end else if (prev_rd_en) begin
                check("rd_without_tap", 1, 0);
            end
            if (done) done_cnt++;

            // next-cycle expectations from the sampled inputs
            xfer   = wr_m && out_ready;
            accept = res_valid && (armed || popped_last) && !wr_m;
            busy_n = busy_m;
            done_n = 0;
            wr_n   = wr_m;
            if (first_cd >= 0) first_cd--;
            if (!busy_m && start) begin
                busy_n   = 1;
                build_frame();
                pix_m    = 0;
                n_xfer   = 0;
                first_cd = 1;
            end
            if (done_m) busy_n = 0;
            if (xfer) begin
                xfer_cyc[pix_m] = cyc;
                n_xfer++;
                if (pix_m == NPIX - 1) done_n = 1;
                else                   first_cd = 1;
                pix_m++;
                wr_n = 0;
            end
            if (accept) begin
                wr_n  = 1;
                armed = 0;
                if (exp_q.size() == 0) check("wr_unexpected", 1, 0);
                else                   wr_addr_m = exp_q.pop_front();
            end else if (popped_last) begin
                armed = 1;
            end
            busy_m         = busy_n;
            done_m         = done_n;
            wr_m           = wr_n;
            prev_rd_en     = rd_en;
            prev_rd_addr   = rd_addr;
            prev_tap_valid = tap_valid;
            cyc++;
        end
    end

    // ---------------- sequencing tasks ----------------
    task automatic do_start();
        @(posedge clk);
        start_req = 1'b1;
        @(posedge clk);
        start_req = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int target = done_cnt + 1;
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("done_timeout", done_cnt >= target, 1);
        repeat (3) @(posedge clk);
    endtask

    task automatic check_reads(input string name, input int p, input int exp_a[], input int n);
        check(name, obs_n[p], n);
        for (int i = 0; i < n; i++) check(name, obs_addr[p][i], exp_a[i]);
    endtask

    int rd_p0[]  = '{0, 1, 4, 5};
    int rd_p5[]  = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    int rd_p11[] = '{6, 7, 10, 11};
    int done_before, n;

    initial begin
        cyc = 0; done_cnt = 0; n_xfer = 0;
        model_reset();

        // model pins: border pad masks of corner pixels
        build_frame();
        check("model_pad_p0", pad_mask(0), 9'h04F);
        check("model_pad_p5", pad_mask(5), 9'h000);
        check("model_pad_p11", pad_mask(11), 9'h1E4);
        model_reset();

        repeat (3) @(posedge clk);
        check("rst_outputs", {busy, done, rd_en, rd_addr, tap_valid, tap_pad, tap_idx,
                              tap_first, tap_last, wr_en, wr_addr, dbg_state}, 0);
        @(posedge clk);
        #2 rst = 1'b0;

        // frame 1: res_valid and out_ready tied high
        mode = 0;
        do_start();
        wait_done(2000);
        check_reads("reads_p0", 0, rd_p0, 4);
        check_reads("reads_p5", 5, rd_p5, 9);
        check_reads("reads_p11", 11, rd_p11, 4);
        check("writes_f1", n_xfer, NPIX);
        check("pixel_period", xfer_cyc[1] - xfer_cyc[0], 11);
        check("pixel_period_row", xfer_cyc[4] - xfer_cyc[3], 11);

        // frame 2: output stall on pixel 2, late result and stray pulse on pixel 3
        mode = 2; noise_en = 1'b1; hold_cnt = 0;
        do_start();
        wait_done(3000);
        check("hold_cycles", hold_cnt, 5);
        check("writes_f2", n_xfer, NPIX);

        // frame 3: abort with reset during FETCH of pixel 5
        mode = 0; noise_en = 1'b0;
        do_start();
        n = 0;
        while (pix_m != 5 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        check("reach_pixel5", pix_m, 5);
        repeat (3) @(posedge clk);
        done_before = done_cnt;
        #1 rst = 1'b1;
        #1;
        check("abort_outputs", {busy, done, rd_en, rd_addr, tap_valid, tap_pad, tap_idx,
                                tap_first, tap_last, wr_en, wr_addr}, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (4) @(posedge clk);
        check("no_done_on_abort", done_cnt, done_before);
        check("idle_after_abort", busy, 0);

        // frame 4: random handshakes after the abort
        mode = 1; noise_en = 1'b1;
        do_start();
        wait_done(6000);
        check("restart_first_read", obs_addr[0][0], 0);
        check("writes_f4", n_xfer, NPIX);
        check("done_pulses", done_cnt, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/conv3x3_scheduler.md
Name: conv3x3_scheduler

Overview:
- Sequencing controller for the 3x3 convolution datapath.
- Walks the image in raster order and issues nine tap reads per output pixel to the input BRAM, with zero-padding flags at the image borders.
- Drives tap-valid, first and last strobes to the MAC engine, waits for its result, then issues the output-BRAM write with a ready/valid handshake.
- Sits between the top-level start/done control and the BRAM/MAC datapath.

Parameters:
IMG_W, 256, image width in pixels (>=2)
IMG_H, 256, image height in pixels (>=2)
ADDR_W, 16, BRAM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  begin a frame; sampled only in IDLE
busy  out  1  high from the cycle after start is accepted until the cycle done pulses (inclusive)
done  out  1  one-cycle pulse after the last pixel write completes
rd_en  out  1  input-BRAM read enable (1-cycle read latency)
rd_addr  out  ADDR_W  input-BRAM read address
tap_valid  out  1  MAC tap strobe, aligned with BRAM read data
tap_pad  out  1  MAC must use 0 instead of the BRAM data for this tap
tap_idx  out  4  kernel coefficient index 0..8
tap_first  out  1  first tap of a pixel; MAC clears its accumulator
tap_last  out  1  last tap of a pixel
res_valid  in  1  MAC result ready for the current pixel
wr_en  out  1  output write valid
wr_addr  out  ADDR_W  output-BRAM address, y*IMG_W+x
out_ready  in  1  output side accepts the write

Behaviour:
- All outputs are registered. Reset values: every output is 0, and the state is IDLE. Reset asserted mid-frame aborts immediately; no done pulse is produced.
- State machine: IDLE -> FETCH -> WAIT -> WRITE -> (FETCH | DONE) -> IDLE.
- IDLE
  - start=1 at a rising edge: x=0, y=0, tap counter k=0, go to FETCH.
  - start is ignored in all other states.
- FETCH (exactly 9 cycles, k=0..8)
  - Tap offsets: dy=k/3-1, dx=k%3-1 (row-major).
  - Tap is padded if x+dx or y+dy falls outside [0,IMG_W-1] or [0,IMG_H-1].
  - Not padded: rd_en=1 and rd_addr=(y+dy)*IMG_W+(x+dx).
  - Padded: rd_en=0 and rd_addr=0.
  - One cycle later (aligned with read data): tap_valid=1, tap_idx=k, tap_pad=padded, tap_first=(k==0), tap_last=(k==8).
  - After k=8, go to WAIT.
- WAIT
  - Hold until res_valid=1.
  - res_valid may arrive as early as the cycle the k=8 tap_valid is presented; a result in that cycle counts.
  - On res_valid: wr_addr=y*IMG_W+x, wr_en=1, go to WRITE.
  - res_valid in any state other than WAIT (or that final tap_valid cycle) is ignored.
- WRITE
  - wr_en and wr_addr stay stable until out_ready=1.
  - Transfer occurs on a cycle with wr_en&out_ready. wr_en drops in the next cycle.
  - On transfer of the last pixel (x=IMG_W-1, y=IMG_H-1): go to DONE.
  - Otherwise advance: x+1, or if x=IMG_W-1 then x=0 and y+1. Reset k=0 and go to FETCH.
- DONE: done=1 for one cycle, busy still 1, then IDLE with busy=0.
- Address arithmetic: computed at ADDR_W bits with no wrap. Border tests use signed or widened coordinates so that x-1 at x=0 is detected, not wrapped.
- Throughput: 9 FETCH + >=1 WAIT + >=1 WRITE cycles per pixel. Minimum 11 cycles per pixel with res_valid and out_ready held high.

Test Plan:
1. IMG_W=4, IMG_H=3; start pulse, res_valid and out_ready tied 1 -> busy rises the next cycle; pixel (0,0) pads taps 0,1,2,3,6 and reads addresses 0,1,4,5 on taps 4,5,7,8; tap_first only on idx0, tap_last only on idx8.
2. Same config, pixel (1,1) -> nine reads at addresses 0,1,2,4,5,6,8,9,10; no pads; wr_addr=5.
3. Pixel (3,2) -> pads taps 2,5,6,7,8; reads 6,7,10,11 on taps 0,1,3,4; wr_addr=11, followed by a single done pulse; 12 writes total covering addresses 0..11 in order.
4. Hold out_ready=0 for 5 cycles at pixel (2,0) -> wr_en=1 and wr_addr=2 stable throughout, no new rd_en; the transfer occurs on the first cycle out_ready=1.
5. Delay res_valid 7 cycles after tap_last -> WAIT holds with rd_en=0 and wr_en=0; a res_valid pulse during FETCH is ignored; wr_en rises the cycle after the real res_valid.
6. Assert rst during FETCH of pixel 5 -> all outputs 0 immediately with no done pulse; start pulses while busy are ignored; a new start after reset restarts at (0,0) with rd_addr=0 on tap 4.
